// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: runs one GCD job at a time on an external core program.
// Sequence per job: reset core, load operands, run until the core reaches FIN_ADDR or TIMEOUT, drain, respond.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   job_valid/job_ready/job_a/job_b       job request channel
//   res_valid/res_ready/res_g/res_timeout result channel
//   core_rst/core_en/core_load            core control
//   core_a/core_b                         operands written into the core on core_load
//   core_addr/core_result                 core program address and result register
//   busy                                  high outside IDLE
module gcd_job_sequencer #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 8,
  parameter int FIN_ADDR = 9,
  parameter int RST_CYCLES = 1,
  parameter int DRAIN_CYCLES = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [WIDTH-1:0]  job_a,
  input  logic [WIDTH-1:0]  job_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_g,
  output logic              res_timeout,
  output logic              core_rst,
  output logic              core_en,
  output logic              core_load,
  output logic [WIDTH-1:0]  core_a,
  output logic [WIDTH-1:0]  core_b,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [WIDTH-1:0]  core_result,
  output logic              busy
);
  localparam logic [2:0] IDLE = 3'd0, RST_CORE = 3'd1, LOAD = 3'd2, RUN = 3'd3, DRAIN = 3'd4, RESP = 3'd5;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int RW = $clog2(RST_CYCLES + 1) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam int AW = RW > DW ? RW : DW;
  logic [2:0] state;
  logic [CW-1:0] run_cnt;
  logic [AW-1:0] aux_cnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic fin;
  assign fin = core_addr == ADDR_W'(FIN_ADDR);
  // control outputs are decoded from state; rst overrides so nothing leaks during a reset cycle
  assign job_ready = !rst && state == IDLE;
  assign busy = !rst && state != IDLE;
  assign core_rst = rst || state == RST_CORE;
  assign core_load = !rst && state == LOAD;
  assign core_en = !rst && (state == RUN || state == DRAIN);
  assign res_valid = !rst && state == RESP;
  assign core_a = op_a;
  assign core_b = op_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run_cnt <= '0;
      aux_cnt <= '0;
      res_g <= '0;
      res_timeout <= 1'b0;
      op_a <= '0;
      op_b <= '0;
    end else begin
      case (state)
        IDLE: if (job_valid) begin
          op_a <= job_a;
          op_b <= job_b;
          aux_cnt <= '0;
          state <= RST_CORE;
        end
        RST_CORE: if (aux_cnt == AW'(RST_CYCLES - 1)) begin
          aux_cnt <= '0;
          state <= LOAD;
        end else aux_cnt <= aux_cnt + 1'b1;
        LOAD: begin
          run_cnt <= '0;
          state <= RUN;
        end
        // completion wins over timeout when both occur in the same cycle
        RUN: if (fin) begin
          if (DRAIN_CYCLES == 0) begin
            res_g <= core_result;
            res_timeout <= 1'b0;
            state <= RESP;
          end else begin
            aux_cnt <= '0;
            state <= DRAIN;
          end
        end else if (run_cnt == CW'(TIMEOUT - 1)) begin
          res_g <= core_result;
          res_timeout <= 1'b1;
          state <= RESP;
        end else run_cnt <= run_cnt + 1'b1;
        DRAIN: if (aux_cnt == AW'(DRAIN_CYCLES - 1)) begin
          res_g <= core_result;
          res_timeout <= 1'b0;
          state <= RESP;
        end else aux_cnt <= aux_cnt + 1'b1;
        RESP: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
